// File: rtl/iob_boot_copier_pkg.sv
// Shared definitions for the boot image copier: FSM state encoding and
// the word-to-byte address shift helper.
package iob_boot_copier_pkg;

  // FSM state encoding (3-bit)
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_REQ   = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_REQ   = 3'd3,
    ST_CTRL_REQ = 3'd4
  } state_t;

  // Default bus geometry and the shift that turns a word index into a byte offset
  localparam int DEF_DATA_W = 32;
  localparam int DEF_STRB_W = DEF_DATA_W / 8;
  localparam int ADDR_SHIFT = $clog2(DEF_STRB_W);

  // Byte-offset shift for an arbitrary strobe width
  function automatic int addr_shift_f(input int strb_w);
    return $clog2(strb_w);
  endfunction

endpackage

// File: rtl/iob_boot_copier.sv
// IOb bus initiator that copies a boot image word by word from a source
// region into destination SRAM, then writes the boot control word that
// clears the boot flag and requests the CPU reset pulse.
module iob_boot_copier
  import iob_boot_copier_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                STRB_W    = DATA_W / 8,
  parameter int                LEN_W     = 16,
  parameter logic [ADDR_W-1:0] SRC_BASE  = '0,
  parameter logic [ADDR_W-1:0] DST_BASE  = '0,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = '0,
  parameter logic [DATA_W-1:0] CTRL_DATA = DATA_W'(2)
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              iob_avalid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [DATA_W-1:0] iob_wdata_o,
  output logic [STRB_W-1:0] iob_wstrb_o,
  input  logic              iob_rvalid_i,
  input  logic [DATA_W-1:0] iob_rdata_i,
  input  logic              iob_ready_i
);

  localparam int SHIFT = addr_shift_f(STRB_W);

  state_t            state;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;
  logic              avalid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              last_word;
  logic [LEN_W-1:0]  idx_nxt;

  // Byte address of word i in a region; wraps modulo 2^ADDR_W without a flag
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  i);
    logic [ADDR_W+LEN_W-1:0] wide;
    wide = {{ADDR_W{1'b0}}, i} << SHIFT;
    return base + wide[ADDR_W-1:0];
  endfunction

  // len_q is nonzero whenever the copy loop runs, so len_q-1 never underflows there
  assign last_word = (idx == len_q - LEN_W'(1));
  assign idx_nxt   = idx + LEN_W'(1);

  // Copy FSM; every bus output is a register so requests stay stable while stalled
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        state    <= ST_IDLE;
        idx      <= '0;
        len_q    <= '0;
        done_q   <= 1'b0;
        avalid_q <= 1'b0;
        addr_q   <= '0;
        wdata_q  <= '0;
        wstrb_q  <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_i) begin
              len_q    <= len_i;
              idx      <= '0;
              done_q   <= 1'b0;
              avalid_q <= 1'b1;
              if (len_i != '0) begin
                state   <= ST_RD_REQ;
                addr_q  <= word_addr(SRC_BASE, '0);
                wdata_q <= '0;
                wstrb_q <= '0;
              end else begin
                // Empty image: go straight to the boot control write
                state   <= ST_CTRL_REQ;
                addr_q  <= CTRL_ADDR;
                wdata_q <= CTRL_DATA;
                wstrb_q <= '1;
              end
            end
          end

          ST_RD_REQ: begin
            if (iob_ready_i) begin
              state    <= ST_RD_WAIT;
              avalid_q <= 1'b0;
              wdata_q  <= '0;
              wstrb_q  <= '0;
            end
          end

          ST_RD_WAIT: begin
            // Only this state listens to rvalid; stray pulses elsewhere are dropped
            if (iob_rvalid_i) begin
              data_q   <= iob_rdata_i;
              state    <= ST_WR_REQ;
              avalid_q <= 1'b1;
              addr_q   <= word_addr(DST_BASE, idx);
              wdata_q  <= iob_rdata_i;
              wstrb_q  <= '1;
            end
          end

          ST_WR_REQ: begin
            if (iob_ready_i) begin
              if (last_word) begin
                state   <= ST_CTRL_REQ;
                addr_q  <= CTRL_ADDR;
                wdata_q <= CTRL_DATA;
                wstrb_q <= '1;
              end else begin
                idx     <= idx_nxt;
                state   <= ST_RD_REQ;
                addr_q  <= word_addr(SRC_BASE, idx_nxt);
                wdata_q <= '0;
                wstrb_q <= '0;
              end
            end else begin
              // Write data is the captured word for as long as the request waits
              wdata_q <= data_q;
            end
          end

          ST_CTRL_REQ: begin
            if (iob_ready_i) begin
              state    <= ST_IDLE;
              done_q   <= 1'b1;
              avalid_q <= 1'b0;
              wdata_q  <= '0;
              wstrb_q  <= '0;
            end
          end

          default: begin
            state    <= ST_IDLE;
            avalid_q <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
          end
        endcase
      end
    end
  end

  assign busy_o       = (state != ST_IDLE);
  assign done_o       = done_q;
  assign iob_avalid_o = avalid_q;
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = wstrb_q;

endmodule

// File: tb/tb_iob_boot_copier.sv
// Directed bench for iob_boot_copier with a small IOb slave model holding
// a source image and a destination memory, plus a request log.
module tb_iob_boot_copier;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          STRB_W = 4;
  localparam int          LEN_W  = 16;
  localparam logic [31:0] SRC    = 32'h0000_1000;
  localparam logic [31:0] DST    = 32'h0000_8000;
  localparam logic [31:0] CADDR  = 32'h0000_F000;
  localparam logic [31:0] CDATA  = 32'h0000_0002;

  logic        clk = 1'b0;
  logic        cke, rst, start;
  logic [15:0] len;
  logic        busy, done, avalid, rvalid, ready;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  iob_boot_copier #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .LEN_W(LEN_W),
    .SRC_BASE(SRC), .DST_BASE(DST), .CTRL_ADDR(CADDR), .CTRL_DATA(CDATA)
  ) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .start_i(start), .len_i(len),
    .busy_o(busy), .done_o(done),
    .iob_avalid_o(avalid), .iob_addr_o(addr), .iob_wdata_o(wdata), .iob_wstrb_o(wstrb),
    .iob_rvalid_i(rvalid), .iob_rdata_i(rdata), .iob_ready_i(ready)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] src_mem [16];
  logic [31:0] dst_mem [16];

  int total = 0;
  int bad   = 0;

  // Slave model state
  logic        stall_en = 1'b0;
  logic        spur_en  = 1'b0;
  int          wait_tbl [8] = '{0, 3, 5, 1, 2, 4, 0, 5};
  int          dly_tbl  [4] = '{1, 4, 2, 3};
  int          wcnt = 0, tcount = 0, rcount = 0, rd_cnt = 0;
  int          cur_wait, cur_dly;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_data = '0;

  function automatic logic [3:0] widx(input logic [31:0] a, input logic [31:0] base);
    logic [31:0] t;
    t = (a - base) >> 2;
    return t[3:0];
  endfunction

  always_comb begin
    cur_wait = stall_en ? wait_tbl[tcount % 8] : 0;
    cur_dly  = stall_en ? dly_tbl[rcount % 4] : 1;
  end

  assign ready  = avalid && cke && (wcnt >= cur_wait);
  assign rvalid = (rd_pend && rd_cnt == 0) || (spur_en && avalid);
  assign rdata  = (rd_pend && rd_cnt == 0) ? rd_data : 32'hDEAD_BEEF;

  // Slave: accepts requests after cur_wait cycles, returns read data cur_dly cycles later
  always @(posedge clk) begin
    if (cke) begin
      if (rd_pend) begin
        if (rd_cnt == 0) rd_pend <= 1'b0;
        else             rd_cnt  <= rd_cnt - 1;
      end
      if (ready) begin
        wcnt   <= 0;
        tcount <= tcount + 1;
        log_q.push_back('{a: addr, d: wdata, s: wstrb});
        if (wstrb == 4'h0) begin
          rd_pend <= 1'b1;
          rd_cnt  <= cur_dly - 1;
          rd_data <= src_mem[widx(addr, SRC)];
          rcount  <= rcount + 1;
        end else if (addr >= DST && addr < DST + 32'd64) begin
          dst_mem[widx(addr, DST)] <= wdata;
        end
      end else if (avalid) begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Request stability monitor across stalled cycles
  logic        prev_stall = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [3:0]  p_wstrb = '0;
  int          stall_bad = 0, stall_seen = 0;

  always @(negedge clk) begin
    if (prev_stall) begin
      stall_seen <= stall_seen + 1;
      if (avalid !== 1'b1 || addr !== p_addr || wdata !== p_wdata || wstrb !== p_wstrb)
        stall_bad <= stall_bad + 1;
    end
    prev_stall <= (avalid === 1'b1) && (ready === 1'b0);
    p_addr     <= addr;
    p_wdata    <= wdata;
    p_wstrb    <= wstrb;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, {63'd0, done}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_t1 [4];
    int          n_rd, n_wr, n_ct;
    exp_t1 = '{32'hA0B0_0000, 32'hA0B1_0101, 32'hA0B2_0202, 32'hA0B3_0303};

    for (int i = 0; i < 16; i++) begin
      src_mem[i] = 32'hA0B0_0000 + i * 32'h0001_0101;
      dst_mem[i] = '0;
    end
    cke = 1'b1; rst = 1'b1; start = 1'b0; len = '0;
    @(negedge clk);
    repeat (2) step();

    // Reset state
    chk("rst_avalid", {63'd0, avalid}, 64'd0);
    chk("rst_addr",   {32'd0, addr},   64'd0);
    chk("rst_wdata",  {32'd0, wdata},  64'd0);
    chk("rst_wstrb",  {60'd0, wstrb},  64'd0);
    chk("rst_busy",   {63'd0, busy},   64'd0);
    chk("rst_done",   {63'd0, done},   64'd0);
    rst = 1'b0;
    step();

    // len=4, zero-wait slave: exact cycle timing and transaction sequence
    log_q.delete();
    len = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_first_avalid", {63'd0, avalid}, 64'd1);
    chk("t1_first_busy",   {63'd0, busy},   64'd1);
    chk("t1_first_addr",   {32'd0, addr},   64'h1000);
    chk("t1_first_wstrb",  {60'd0, wstrb},  64'd0);
    repeat (12) step();
    chk("t1_ctrl_avalid", {63'd0, avalid}, 64'd1);
    chk("t1_ctrl_addr",   {32'd0, addr},   64'hF000);
    chk("t1_ctrl_wdata",  {32'd0, wdata},  64'h2);
    chk("t1_ctrl_done0",  {63'd0, done},   64'd0);
    step();
    chk("t1_done_c14",   {63'd0, done},   64'd1);
    chk("t1_busy_c14",   {63'd0, busy},   64'd0);
    chk("t1_avalid_c14", {63'd0, avalid}, 64'd0);
    chk("t1_wdata_idle", {32'd0, wdata},  64'd0);
    chk("t1_log_size", 64'(log_q.size()), 64'd9);
    if (log_q.size() == 9) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t1_rd%0d_addr", i),  {32'd0, log_q[2*i].a},   64'(32'h1000 + 4 * i));
        chk($sformatf("t1_rd%0d_strb", i),  {60'd0, log_q[2*i].s},   64'd0);
        chk($sformatf("t1_wr%0d_addr", i),  {32'd0, log_q[2*i+1].a}, 64'(32'h8000 + 4 * i));
        chk($sformatf("t1_wr%0d_data", i),  {32'd0, log_q[2*i+1].d}, {32'd0, exp_t1[i]});
        chk($sformatf("t1_wr%0d_strb", i),  {60'd0, log_q[2*i+1].s}, 64'hF);
      end
      chk("t1_ctrl_log_addr", {32'd0, log_q[8].a}, 64'hF000);
      chk("t1_ctrl_log_data", {32'd0, log_q[8].d}, 64'h2);
      chk("t1_ctrl_log_strb", {60'd0, log_q[8].s}, 64'hF);
    end
    repeat (2) step();
    chk("t1_done_sticky", {63'd0, done}, 64'd1);

    // len=0: single control write right after start
    log_q.delete();
    len = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_avalid", {63'd0, avalid}, 64'd1);
    chk("t2_addr",   {32'd0, addr},   64'hF000);
    chk("t2_wdata",  {32'd0, wdata},  64'h2);
    chk("t2_wstrb",  {60'd0, wstrb},  64'hF);
    chk("t2_done_cleared", {63'd0, done}, 64'd0);
    step();
    chk("t2_done", {63'd0, done}, 64'd1);
    chk("t2_busy", {63'd0, busy}, 64'd0);
    chk("t2_log_size", 64'(log_q.size()), 64'd1);

    // Clock enable low freezes a pending request
    log_q.delete();
    len = 16'd0; start = 1'b1;
    step();
    start = 1'b0; cke = 1'b0;
    repeat (3) step();
    chk("cke_avalid_hold", {63'd0, avalid}, 64'd1);
    chk("cke_addr_hold",   {32'd0, addr},   64'hF000);
    chk("cke_busy_hold",   {63'd0, busy},   64'd1);
    chk("cke_done_hold",   {63'd0, done},   64'd0);
    cke = 1'b1;
    step();
    chk("cke_done_after", {63'd0, done}, 64'd1);

    // Stalls, rvalid delays and spurious rvalid outside RD_WAIT
    for (int i = 0; i < 16; i++) dst_mem[i] = '0;
    log_q.delete();
    stall_en = 1'b1; spur_en = 1'b1;
    len = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(400, "t3_timeout");
    stall_en = 1'b0; spur_en = 1'b0;
    step();
    for (int i = 0; i < 5; i++)
      chk($sformatf("t3_dst%0d", i), {32'd0, dst_mem[i]}, {32'd0, src_mem[i]});
    chk("t3_dst5_untouched", {32'd0, dst_mem[5]}, 64'd0);
    chk("t3_log_size", 64'(log_q.size()), 64'd11);
    chk("t3_stall_stable", 64'(stall_bad), 64'd0);
    chk("t3_stalls_seen", {63'd0, (stall_seen > 0)}, 64'd1);

    // start pulse with a different len in mid-copy is ignored
    log_q.delete();
    len = 16'd6; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    len = 16'd2; start = 1'b1;
    step();
    start = 1'b0; len = 16'd0;
    wait_done(200, "t4_timeout");
    n_rd = 0; n_wr = 0; n_ct = 0;
    foreach (log_q[i]) begin
      if (log_q[i].s == 4'h0)       n_rd++;
      else if (log_q[i].a == CADDR) n_ct++;
      else                          n_wr++;
    end
    chk("t4_reads",  64'(n_rd), 64'd6);
    chk("t4_writes", 64'(n_wr), 64'd6);
    chk("t4_ctrl",   64'(n_ct), 64'd1);

    // Reset during WR_REQ of word 2, then restart from idx 0
    log_q.delete();
    len = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    chk("t5_in_wr2_addr", {32'd0, addr}, 64'h8008);
    chk("t5_in_wr2_strb", {60'd0, wstrb}, 64'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_avalid", {63'd0, avalid}, 64'd0);
    chk("t5_rst_busy",   {63'd0, busy},   64'd0);
    chk("t5_rst_done",   {63'd0, done},   64'd0);
    chk("t5_rst_wstrb",  {60'd0, wstrb},  64'd0);
    log_q.delete();
    len = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_restart_addr", {32'd0, addr}, 64'h1000);
    wait_done(100, "t5_timeout");
    chk("t5_log_size", 64'(log_q.size()), 64'd5);
    if (log_q.size() == 5) begin
      chk("t5_rd0_addr", {32'd0, log_q[0].a}, 64'h1000);
      chk("t5_wr0_addr", {32'd0, log_q[1].a}, 64'h8000);
      chk("t5_rd1_addr", {32'd0, log_q[2].a}, 64'h1004);
      chk("t5_wr1_data", {32'd0, log_q[3].d}, 64'hA0B1_0101);
      chk("t5_ctrl_addr", {32'd0, log_q[4].a}, 64'hF000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
